// File: rtl/sdram_arb2.sv
// Two-client round-robin arbiter in front of the single sdram_ctrl request/ack port.
// Serialises single-word accesses, routes ack/read data back to the owner, and aborts hung accesses.
module sdram_arb2 #(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              c0_req,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic              c0_rh_wl,
    input  logic [DATA_W-1:0] c0_data_w,
    output logic              c0_ack,
    output logic              c0_err,
    output logic [DATA_W-1:0] c0_data_r,
    output logic              c0_data_r_en,

    input  logic              c1_req,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic              c1_rh_wl,
    input  logic [DATA_W-1:0] c1_data_w,
    output logic              c1_ack,
    output logic              c1_err,
    output logic [DATA_W-1:0] c1_data_r,
    output logic              c1_data_r_en,

    output logic              sdram_req,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              sdram_rh_wl,
    output logic [DATA_W-1:0] sdram_data_w,
    input  logic              sdram_ack,
    input  logic [DATA_W-1:0] sdram_data_r,
    input  logic              sdram_data_r_en,

    output logic              timeout_flag
);

    localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state_q;
    logic              owner_q;
    logic              prio_q;
    logic [WD_W-1:0]   wd_q;
    logic [1:0]        ack_q;
    logic [1:0]        err_q;
    logic              req_q;
    logic              flag_q;
    logic [ADDR_W-1:0] addr_q;
    logic              rh_wl_q;
    logic [DATA_W-1:0] data_w_q;

    logic              any_req_d;
    logic              grant_d;
    logic              in_xfer;

    // A tie goes to the favoured client; otherwise whoever is asking wins.
    always_comb begin
        any_req_d = c0_req | c1_req;
        grant_d   = (c0_req & c1_req) ? prio_q : c1_req;
    end

    // NOTE: every register here is assigned with <= so all of them update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            prio_q   <= 1'b0;
            wd_q     <= '0;
            ack_q    <= '0;
            err_q    <= '0;
            req_q    <= 1'b0;
            flag_q   <= 1'b0;
            addr_q   <= '0;
            rh_wl_q  <= 1'b1;
            data_w_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_req_d) begin
                        owner_q  <= grant_d;
                        prio_q   <= ~grant_d;
                        addr_q   <= grant_d ? c1_addr   : c0_addr;
                        rh_wl_q  <= grant_d ? c1_rh_wl  : c0_rh_wl;
                        data_w_q <= grant_d ? c1_data_w : c0_data_w;
                        req_q    <= 1'b1;
                        state_q  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    req_q   <= 1'b0;
                    wd_q    <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (sdram_ack) begin
                        ack_q[owner_q] <= 1'b1;
                        state_q        <= S_DONE;
                    end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                        ack_q[owner_q] <= 1'b1;
                        err_q[owner_q] <= 1'b1;
                        flag_q         <= 1'b1;
                        state_q        <= S_DONE;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                S_DONE: begin
                    ack_q   <= '0;
                    err_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Read data is only forwarded while a read access of that client is in flight or completing.
    assign in_xfer = (state_q == S_WAIT) || (state_q == S_DONE);

    assign c0_ack       = ack_q[0];
    assign c1_ack       = ack_q[1];
    assign c0_err       = err_q[0];
    assign c1_err       = err_q[1];
    assign c0_data_r    = sdram_data_r;
    assign c1_data_r    = sdram_data_r;
    assign c0_data_r_en = sdram_data_r_en & rh_wl_q & ~owner_q & in_xfer;
    assign c1_data_r_en = sdram_data_r_en & rh_wl_q &  owner_q & in_xfer;

    assign sdram_req    = req_q;
    assign sdram_addr   = addr_q;
    assign sdram_rh_wl  = rh_wl_q;
    assign sdram_data_w = data_w_q;
    assign timeout_flag = flag_q;

endmodule

// File: doc/sdram_arb2.md
# sdram_arb2

Two-port round-robin arbiter that shares the single `sdram_ctrl` request/ack port between two independent requesters (e.g. a test pattern engine and a display/readback engine). It sits between the clients and `sdram_ctrl` and serialises single-word accesses. It registers the winning request's address, direction and write data, and issues the one-cycle `sdram_req` pulse. It routes the completion ack and read data back to the owning client, and aborts a hung access with a watchdog.

## Interface
- `ADDR_W`, 24, SDRAM word address width (row+col+bank, 13+9+2)
- `DATA_W`, 16, data width
- `TIMEOUT_CYC`, 1023, max cycles in WAIT before abort (≥2)
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `c0_req`, `c1_req`  in  1 each  level request; hold until matching ack
- `c0_addr`, `c1_addr`  in  ADDR_W each  word address; stable while req high
- `c0_rh_wl`, `c1_rh_wl`  in  1 each  1=read, 0=write; stable while req high
- `c0_data_w`, `c1_data_w`  in  DATA_W each  write data; stable while req high
- `c0_ack`, `c1_ack`  out  1 each  one-cycle completion pulse
- `c0_err`, `c1_err`  out  1 each  one-cycle, coincident with ack, when access timed out
- `c0_data_r`, `c1_data_r`  out  DATA_W each  read data (= `sdram_data_r`)
- `c0_data_r_en`, `c1_data_r_en`  out  1 each  read data valid for that client
- `sdram_req`  out  1  one-cycle access start pulse to controller
- `sdram_addr`  out  ADDR_W  registered access address
- `sdram_rh_wl`  out  1  registered direction
- `sdram_data_w`  out  DATA_W  registered write data
- `sdram_ack`  in  1  controller completion pulse
- `sdram_data_r`  in  DATA_W  controller read data
- `sdram_data_r_en`  in  1  controller read data valid
- `timeout_flag`  out  1  sticky; set on any abort, cleared only by reset

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Registers: `owner` (0/1), `prio` (client favoured on tie), watchdog counter, `sdram_*` outputs.
- IDLE: if exactly one `cN_req` high → grant N; if both high → grant `prio`. On grant: `owner`<=N, latch `cN_addr/rh_wl/data_w` into `sdram_addr/rh_wl/data_w`, `sdram_req`<=1, `prio`<=other client, → ISSUE.
- ISSUE: `sdram_req`<=0, watchdog<=0, → WAIT. `sdram_req` is high for exactly the ISSUE cycle.
- WAIT: on `sdram_ack` → `c[owner]_ack`<=1, → DONE. Otherwise watchdog++. When it reaches `TIMEOUT_CYC-1` without ack → `c[owner]_ack`<=1, `c[owner]_err`<=1, `timeout_flag`<=1, → DONE.
- DONE: ack/err<=0, → IDLE. This cycle lets the client drop `req`. A req still high in IDLE is a new request.
- `sdram_ack` outside WAIT is ignored.
- Read routing (combinational):
  - `cN_data_r` = `sdram_data_r`.
  - `cN_data_r_en` = `sdram_data_r_en` & `sdram_rh_wl` & (`owner`==N) & (state WAIT or DONE).
- `sdram_addr/rh_wl/data_w` hold their values from grant until the next grant.

## Timing
- Reset values: all acks/errs/`sdram_req`/`timeout_flag`/data_r_en = 0; `sdram_addr`=0; `sdram_data_w`=0; `sdram_rh_wl`=1; `owner`=0; `prio`=0 (client 0); state IDLE.
- Req sampled high at edge E (IDLE) → `sdram_req` high in cycle E+1.
- `sdram_ack` sampled at edge A → `cN_ack` high in cycle A+1 → IDLE in cycle A+2.
- Minimum turnaround, req to next grant: 3 cycles of arbiter overhead plus controller latency.
- Back-to-back holding clients alternate strictly. A single holding client is re-granted every turnaround.
- Simultaneous requests after reset: client 0 first.
- Timeout: ack/err pulse in cycle ISSUE+1+`TIMEOUT_CYC`. A late `sdram_ack` after abort is discarded.
- Reset mid-access: IDLE next cycle, all outputs to reset values. The controller must be reset by the same `reset`.

## Test plan
- Write only c0 (addr 0x000000, data 0xF055, rh_wl=0), controller acks 5 cycles after req → `sdram_req` 1 cycle with addr 0/data 0xF055/rh_wl 0; `c0_ack` one pulse exactly 1 cycle after `sdram_ack`; `c1_ack` never.
- c0 and c1 raise req the same cycle after reset → c0 served first, then c1. `sdram_addr` takes c0 then c1 value; no overlap of ack pulses.
- Both hold req for 6 accesses → grant order 0,1,0,1,0,1; each `sdram_req` separated by ≥3 cycles + controller latency.
- c1 read addr 0x000123, controller returns 0xA5A5 with `sdram_data_r_en` → `c1_data_r_en`=1 with `c1_data_r`=0xA5A5. `c0_data_r_en` stays 0 throughout.
- Controller never acks (`TIMEOUT_CYC`=16) → `c0_ack`+`c0_err` pulse 17 cycles after `sdram_req`; `timeout_flag`=1 until reset; late `sdram_ack` produces no client ack.
- Assert `reset` while in WAIT → next cycle IDLE, all outputs at reset values, `sdram_rh_wl`=1; fresh c1 req is granted normally.
